// File: rtl/dual_port_mem_arbiter.sv
// Shares one single-port synchronous RAM between a read-only fetch port and a
// read/write data port. Reads are tagged so each response returns to its issuer.
module dual_port_mem_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_wren,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
  } tag_t;

  tag_t       tag_q [RD_LATENCY];
  tag_t       tag_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       fetch_wins;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; that is what keeps these blocks from inferring latches.
  always_comb begin
    fetch_wins = 1'b0;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    // Grants are forced low while reset is held, even though inputs may be active.
    if (reset) begin
      fetch_wins = if_req && (!d_req || (starve_cnt_q == LIMIT));
      if_gnt     = fetch_wins;
      d_gnt      = d_req && !fetch_wins;
    end
  end

  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    if (if_gnt) begin
      mem_address = if_addr;
    end else if (d_gnt) begin
      mem_address = d_addr;
      mem_wren    = d_wren;
      mem_data    = d_wren ? d_wdata : '0;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (if_gnt || !if_req) begin
      starve_cnt_d = '0;
    end else if (d_gnt && (starve_cnt_q != LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_comb begin
    tag_d       = '0;
    tag_d.valid = if_gnt || (d_gnt && !d_wren);
    tag_d.port  = d_gnt ? PORT_D : PORT_IF;
  end

  // NOTE: sequential state uses non-blocking assignments so every stage of the
  // tag shift register samples its predecessor's pre-edge value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      tag_q[0]     <= tag_d;
      for (int i = 1; i < RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign if_rvalid = tag_q[RD_LATENCY-1].valid && (tag_q[RD_LATENCY-1].port == PORT_IF);
  assign d_rvalid  = tag_q[RD_LATENCY-1].valid && (tag_q[RD_LATENCY-1].port == PORT_D);
  assign if_rdata  = mem_q;
  assign d_rdata   = mem_q;

endmodule

// File: tb/tb_dual_port_mem_arbiter.sv
// Bench for dual_port_mem_arbiter: three instances (read latency 1, 3, 2) share
// one stimulus stream; a cycle-indexed model predicts grants and responses.
module tb_dual_port_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SL = 3;
  localparam int NI = 3;
  localparam int HN = 2048;

  logic clock = 1'b0;
  logic reset;
  logic if_req, d_req, d_wren;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;

  logic [NI-1:0]         if_gnt_w, if_rvalid_w, d_gnt_w, d_rvalid_w, mem_wren_w;
  logic [NI-1:0][DW-1:0] if_rdata_w, d_rdata_w, mem_data_w, mem_q_w;
  logic [NI-1:0][AW-1:0] mem_address_w;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 3 : 2);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
    logic [DW-1:0] ram [4096];
    logic [DW-1:0] qp  [LAT];

    dual_port_mem_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT), .STARVE_LIMIT(SL)
    ) dut (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_w[g]),
      .if_rvalid(if_rvalid_w[g]), .if_rdata(if_rdata_w[g]),
      .d_req(d_req), .d_wren(d_wren), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt_w[g]), .d_rvalid(d_rvalid_w[g]), .d_rdata(d_rdata_w[g]),
      .mem_address(mem_address_w[g]), .mem_data(mem_data_w[g]),
      .mem_wren(mem_wren_w[g]), .mem_q(mem_q_w[g])
    );

    initial begin
      for (int i = 0; i < 4096; i++) ram[i] <= '0;
      for (int i = 0; i < LAT; i++) qp[i] <= '0;
      ram[12'h010] <= 32'hDEADBEEF;
      for (int i = 1; i <= 4; i++) ram[i] <= 32'h0000_00A0 + 32'(i);
    end

    // Synchronous RAM: address sampled at the edge, data out LAT cycles later.
    always @(posedge clock) begin
      if (mem_wren_w[g]) ram[mem_address_w[g]] <= mem_data_w[g];
      qp[0] <= ram[mem_address_w[g]];
      for (int i = 1; i < LAT; i++) qp[i] <= qp[i-1];
    end
    assign mem_q_w[g] = qp[LAT-1];
  end

  // Model: per-cycle history of issued reads; a response for latency L in cycle t
  // is whatever read was issued in cycle t-L and not wiped by a reset.
  logic [DW-1:0] mmem [4096];
  bit            hv [HN];
  bit            hp [HN];
  logic [DW-1:0] hd [HN];
  int            t = 0;
  int            streak = 0;

  initial begin
    for (int i = 0; i < 4096; i++) mmem[i] = '0;
    mmem[12'h010] = 32'hDEADBEEF;
    for (int i = 1; i <= 4; i++) mmem[i] = 32'h0000_00A0 + 32'(i);
    for (int i = 0; i < HN; i++) begin hv[i] = 0; hp[i] = 0; hd[i] = '0; end
  end

  always @(negedge clock) begin
    logic ef, ed, ew, evi, evd;
    logic [AW-1:0] ea;
    logic [DW-1:0] edat;
    int idx;
    if (!reset) begin
      for (int g = 0; g < NI; g++) begin
        check("rst_ctrl", {if_gnt_w[g], d_gnt_w[g], if_rvalid_w[g], d_rvalid_w[g], mem_wren_w[g]}, '0);
        check("rst_mem", {mem_address_w[g], mem_data_w[g]}, '0);
      end
      for (int i = 0; i < HN; i++) hv[i] = 0;
      streak = 0;
    end else if (t < HN) begin
      ef   = if_req && (!d_req || streak == SL);
      ed   = d_req && !ef;
      ew   = ed && d_wren;
      ea   = ef ? if_addr : (ed ? d_addr : '0);
      edat = ew ? d_wdata : '0;
      for (int g = 0; g < NI; g++) begin
        check("if_gnt", if_gnt_w[g], ef);
        check("d_gnt", d_gnt_w[g], ed);
        check("mem_wren", mem_wren_w[g], ew);
        check("mem_address", mem_address_w[g], ea);
        check("mem_data", mem_data_w[g], edat);
        idx = t - lat_of(g);
        evi = (idx >= 0) && hv[idx] && !hp[idx];
        evd = (idx >= 0) && hv[idx] && hp[idx];
        check("if_rvalid", if_rvalid_w[g], evi);
        check("d_rvalid", d_rvalid_w[g], evd);
        if (evi) check("if_rdata", if_rdata_w[g], hd[idx]);
        if (evd) check("d_rdata", d_rdata_w[g], hd[idx]);
      end
      hv[t] = ef || (ed && !d_wren);
      hp[t] = ed;
      hd[t] = mmem[ea];
      if (ew) mmem[d_addr] = d_wdata;
      if (ef || !if_req) streak = 0;
      else if (ed && streak < SL) streak = streak + 1;
    end
    t++;
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic idle(input int n);
    if_req = 1'b0; d_req = 1'b0; d_wren = 1'b0; d_wdata = '0;
    repeat (n) step();
  endtask

  logic [7:0]    pat, riv, rdv;
  logic [DW-1:0] r3, r4;
  logic [NI-1:0] seen;
  int            fcnt;

  initial begin
    reset = 1'b0; if_req = 1'b1; d_req = 1'b1; d_wren = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;

    // Both requesting: data wins three times, then fetch once.
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      pat[7-i] = if_gnt_w[0];
      if (i == 0) check("first_d_gnt", d_gnt_w, 3'b111);
    end
    check("starve_pattern", pat, 8'b0001_0001);
    step();
    idle(4);

    if_req = 1'b1; if_addr = 12'h010;
    @(negedge clock);
    check("fetch_gnt", if_gnt_w, 3'b111);
    step();
    if_req = 1'b0;
    @(negedge clock);
    check("fetch_rvalid_l1", if_rvalid_w[0], 1'b1);
    check("fetch_rdata_l1", if_rdata_w[0], 32'hDEADBEEF);
    check("fetch_no_d_rvalid", d_rvalid_w[0], 1'b0);
    idle(4);

    d_req = 1'b1; d_wren = 1'b1; d_addr = 12'h020; d_wdata = 32'h12345678;
    @(negedge clock);
    check("write_wren", mem_wren_w, 3'b111);
    check("write_data", mem_data_w[0], 32'h12345678);
    step();
    d_wren = 1'b0; d_wdata = '0;
    @(negedge clock);
    check("read_back_gnt", d_gnt_w, 3'b111);
    step();
    d_req = 1'b0;
    @(negedge clock);
    check("read_back_rvalid", d_rvalid_w[0], 1'b1);
    check("read_back_rdata", d_rdata_w[0], 32'h12345678);
    idle(4);

    // Alternating fetch/data reads of 0x001..0x004 observed on the latency-3 instance.
    for (int k = 0; k < 8; k++) begin
      if_req = (k == 0) || (k == 2);
      d_req  = (k == 1) || (k == 3);
      if_addr = AW'(k + 1);
      d_addr  = AW'(k + 1);
      @(negedge clock);
      riv[k] = if_rvalid_w[1];
      rdv[k] = d_rvalid_w[1];
      if (k == 3) r3 = if_rdata_w[1];
      if (k == 4) r4 = d_rdata_w[1];
      step();
    end
    check("lat3_if_rvalid", riv, 8'b0010_1000);
    check("lat3_d_rvalid", rdv, 8'b0101_0000);
    check("lat3_first_data", r3, 32'h0000_00A1);
    check("lat3_second_data", r4, 32'h0000_00A2);
    idle(2);

    // Fetch waiting behind a stream of data writes still gets one slot in four.
    if_req = 1'b1; if_addr = 12'h005;
    d_req = 1'b1; d_wren = 1'b1; d_addr = 12'h006; d_wdata = 32'hCAFE0006;
    fcnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      fcnt += int'(if_gnt_w[0]);
      if (i < 3) step();
    end
    check("write_stream_fetch_slots", fcnt, 1);
    step();
    idle(4);
    if_req = 1'b1; if_addr = 12'h006;
    step();
    idle(4);

    // Reset one cycle after a fetch grant discards the in-flight read.
    if_req = 1'b1; if_addr = 12'h010;
    @(negedge clock);
    step();
    if_req = 1'b0; reset = 1'b0;
    step();
    reset = 1'b1;
    seen = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      seen |= if_rvalid_w;
    end
    check("midflight_no_rvalid", seen, '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
